cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between result producers (ALU, LSB, spare unit).

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_chk.sv | 35 +++
 rtl/cdb_src_fifo.sv | 85 ++++++++
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default geometry, the null
// ROB tag that consumers never match, and the producer index assignment.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC    = 3;
  localparam int CDB_DEPTH      = 2;
  localparam int CDB_ENTRY_W    = 6;
  localparam int CDB_ENTRY_NULL = 0;

  localparam int CDB_SRC_ALU    = 0;
  localparam int CDB_SRC_LSB    = 1;
  localparam int CDB_SRC_SPARE  = 2;

  // Candidate index examined at search step 'off' when the last winner was 'last'.
  function automatic int rr_index(input int last, input int off, input int n);
    return (last + 1 + off) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_chk.sv
// Simulation-time protocol and occupancy checks for the CDB arbiter.
module cdb_arbiter_chk #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 6,
  parameter int CNT_W   = 2
) (
  input logic                              clk_i,
  input logic                              rst_ni,
  input logic [NUM_SRC-1:0]                push_i,
  input logic [NUM_SRC*ENTRY_W-1:0]        entry_i,
  input logic [NUM_SRC-1:0]                full_i,
  input logic [NUM_SRC-1:0][CNT_W-1:0]     count_i
);
  import cdb_arbiter_pkg::*;

  localparam logic [ENTRY_W-1:0] NULL_TAG = ENTRY_W'(CDB_ENTRY_NULL);

  // A pushed result must carry a real ROB tag; full flag must track the count.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_i[i]) begin
          assert (entry_i[i*ENTRY_W +: ENTRY_W] != NULL_TAG)
            else $error("cdb_arbiter: source %0d pushed the null tag", i);
        end
        assert (count_i[i] <= CNT_W'(DEPTH))
          else $error("cdb_arbiter: source %0d count overflow", i);
        assert (full_i[i] == (count_i[i] == CNT_W'(DEPTH)))
          else $error("cdb_arbiter: source %0d full flag inconsistent", i);
      end
    end
  end

endmodule

// File: rtl/cdb_src_fifo.sv
// Small per-producer result FIFO; flush empties it in one cycle and wins over
// any push or pop offered in the same cycle.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 70,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_i && !pop_i) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; a flushed push is dropped so no stale data is written.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == CNT_W'(0));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one FIFO per producer, rotating-priority grant that
// drains one FIFO head per cycle onto the broadcast bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int DEPTH   = CDB_DEPTH,
  parameter int ENTRY_W = CDB_ENTRY_W,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       roll_back,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*ENTRY_W-1:0] src_entry,
  input  logic [NUM_SRC*32-1:0]      src_value,
  input  logic [NUM_SRC*32-1:0]      src_pc,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       cdb_valid,
  output logic [SRC_W-1:0]           cdb_src,
  output logic [ENTRY_W-1:0]         cdb_entry,
  output logic [31:0]                cdb_value,
  output logic [31:0]                cdb_pc
);

  localparam int ITEM_W = ENTRY_W + 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ENTRY_W-1:0] NULL_TAG = ENTRY_W'(CDB_ENTRY_NULL);
  localparam logic [SRC_W-1:0]   LAST_RST = SRC_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0]              push_s, pop_s, empty_s, full_s;
  logic [NUM_SRC-1:0][ITEM_W-1:0]  head_s;
  logic [NUM_SRC-1:0][CNT_W-1:0]   count_s;
  logic [SRC_W-1:0]                last_grant_q, last_grant_d;
  logic [SRC_W-1:0]                grant_s;
  logic                            grant_vld_s;
  logic [ITEM_W-1:0]               win_item_s;

  // Ready depends only on registered fullness, never on src_valid.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_ready[i] = rdy_in & ~full_s[i];
    assign push_s[i]    = rdy_in & src_valid[i] & ~full_s[i] & ~roll_back;
    assign pop_s[i]     = cdb_valid & (grant_s == SRC_W'(i));

    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ITEM_W)
    ) u_fifo (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .flush_i (roll_back),
      .push_i  (push_s[i]),
      .pop_i   (pop_s[i]),
      .din_i   ({src_entry[i*ENTRY_W +: ENTRY_W], src_value[i*32 +: 32], src_pc[i*32 +: 32]}),
      .dout_o  (head_s[i]),
      .empty_o (empty_s[i]),
      .full_o  (full_s[i]),
      .count_o (count_s[i])
    );
  end

  // Rotating-priority search starting just after the previous winner.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!grant_vld_s && !empty_s[j] &&
            (j == rr_index(int'(last_grant_q), off, NUM_SRC))) begin
          grant_vld_s = 1'b1;
          grant_s     = SRC_W'(j);
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Winner head selection.
  always_comb begin
    win_item_s = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant_s == SRC_W'(j)) begin
        win_item_s = head_s[j];
      end else begin
        win_item_s = win_item_s;
      end
    end
  end

  // Broadcast bus; idle cycles drive the null tag so consumers never wake on stale data.
  always_comb begin
    cdb_valid = rdy_in & grant_vld_s;
    if (cdb_valid) begin
      cdb_src   = grant_s;
      cdb_entry = win_item_s[ITEM_W-1 -: ENTRY_W];
      cdb_value = win_item_s[63:32];
      cdb_pc    = win_item_s[31:0];
    end else begin
      cdb_src   = SRC_W'(CDB_SRC_ALU);
      cdb_entry = NULL_TAG;
      cdb_value = 32'd0;
      cdb_pc    = 32'd0;
    end
  end

  // Last-winner next state: a flush restarts the rotation like reset does.
  always_comb begin
    if (roll_back) begin
      last_grant_d = LAST_RST;
    end else if (cdb_valid) begin
      last_grant_d = grant_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-winner register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      last_grant_q <= LAST_RST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  cdb_arbiter_chk #(
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .CNT_W   (CNT_W)
  ) u_chk (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (push_s),
    .entry_i (src_entry),
    .full_i  (full_s),
    .count_i (count_s)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a per-cycle vector table plus scoreboarded sequences
// for fairness, single-push latency and backpressure.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk_in;
  logic        rst_in, rdy_in, roll_back;
  logic [2:0]  src_valid;
  logic [17:0] src_entry;
  logic [95:0] src_value, src_pc;
  logic [2:0]  src_ready;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic [5:0]  cdb_entry;
  logic [31:0] cdb_value, cdb_pc;

  int   n_cmp;
  int   n_bad;
  logic mon_en;

  typedef struct {
    logic [1:0]  src;
    logic [5:0]  entry;
    logic [31:0] value;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic       rst, rdy, rb;
    logic [2:0] vld;
    logic [5:0] t0, t1, t2;
    logic       ev;
    logic [1:0] es;
    logic [5:0] ee;
    logic [2:0] er;
  } row_t;
  row_t tbl[19];

  cdb_arbiter #(.NUM_SRC(3), .DEPTH(2), .ENTRY_W(6)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .roll_back (roll_back),
    .src_valid (src_valid),
    .src_entry (src_entry),
    .src_value (src_value),
    .src_pc    (src_pc),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_src   (cdb_src),
    .cdb_entry (cdb_entry),
    .cdb_value (cdb_value),
    .cdb_pc    (cdb_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] val_f(input int i, input logic [5:0] t);
    return 32'hA000_0000 | (32'(i) << 16) | {26'd0, t};
  endfunction

  function automatic logic [31:0] pc_f(input int i, input logic [5:0] t);
    return 32'h0000_4000 + (32'(i) << 8) + {24'd0, t, 2'b00};
  endfunction

  function automatic row_t mk(input logic rst, input logic rdy, input logic rb, input logic [2:0] vld,
                              input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                              input logic ev, input logic [1:0] es, input logic [5:0] ee,
                              input logic [2:0] er);
    row_t r;
    r.rst = rst; r.rdy = rdy; r.rb = rb; r.vld = vld;
    r.t0 = t0; r.t1 = t1; r.t2 = t2;
    r.ev = ev; r.es = es; r.ee = ee; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [5:0] t);
    src_valid[i]         = v;
    src_entry[i*6 +: 6]  = t;
    src_value[i*32 +: 32] = val_f(i, t);
    src_pc[i*32 +: 32]    = pc_f(i, t);
  endtask

  task automatic sb_push(input int i, input logic [5:0] t, input logic [31:0] v, input logic [31:0] p);
    exp_t e;
    e.src = 2'(i); e.entry = t; e.value = v; e.pc = p;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic reset_pulse();
    rst_in    = 1'b0;
    src_valid = 3'b000;
    tick();
    rst_in = 1'b1;
  endtask

  task automatic fair_round(input logic [5:0] base);
    for (int i = 0; i < 3; i++) begin
      set_src(i, 1'b1, base + 6'(i));
      sb_push(i, base + 6'(i), val_f(i, base + 6'(i)), pc_f(i, base + 6'(i)));
    end
    tick();
    src_valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk($sformatf("fair%0d_valid_c%0d", base, k), 32'(cdb_valid), 32'd1);
      tick();
    end
    @(negedge clk_in);
    chk($sformatf("fair%0d_idle", base), 32'(cdb_valid), 32'd0);
    tick();
  endtask

  // Scoreboard monitor: every broadcast must match the oldest expected result.
  always @(negedge clk_in) begin
    exp_t e;
    if (mon_en && cdb_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got src %0d tag %0d, want no broadcast", cdb_src, cdb_entry);
      end else begin
        e = sb_q.pop_front();
        if ({cdb_src, cdb_entry, cdb_value, cdb_pc} !== {e.src, e.entry, e.value, e.pc}) begin
          n_bad++;
          $display("FAIL sb_bcast: got src %0d tag %0d val %h pc %h, want src %0d tag %0d val %h pc %h",
                   cdb_src, cdb_entry, cdb_value, cdb_pc, e.src, e.entry, e.value, e.pc);
        end
      end
    end
  end

  initial begin
    int   t0, t1;
    logic acc0, acc1;
    n_cmp = 0; n_bad = 0; mon_en = 1'b0;
    rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0;
    src_valid = '0; src_entry = '0; src_value = '0; src_pc = '0;
    set_src(0, 1'b1, 6'd1); set_src(1, 1'b1, 6'd2); set_src(2, 1'b1, 6'd3);
    tick();

    //            rst   rdy   rb    vld     t0     t1     t2     ev    es     ee     er
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 3'b111, 6'd1,  6'd2,  6'd3,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 3'b011, 6'd11, 6'd12, 6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 3'b111, 6'd13, 6'd14, 6'd15, 1'b1, 2'd0, 6'd11, 3'b111);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 3'b100, 6'd0,  6'd0,  6'd20, 1'b1, 2'd1, 6'd12, 3'b101);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 3'b100, 6'd0,  6'd0,  6'd21, 1'b0, 2'd0, 6'd0,  3'b111);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b1, 2'd2, 6'd21, 3'b111);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 3'b001, 6'd7,  6'd0,  6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 3'b111, 6'd30, 6'd31, 6'd32, 1'b0, 2'd0, 6'd0,  3'b000);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 3'b111, 6'd30, 6'd31, 6'd32, 1'b0, 2'd0, 6'd0,  3'b000);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 3'b111, 6'd30, 6'd31, 6'd32, 1'b0, 2'd0, 6'd0,  3'b000);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b1, 2'd0, 6'd7,  3'b111);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 3'b010, 6'd0,  6'd40, 6'd0,  1'b0, 2'd0, 6'd0,  3'b111);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 3'b010, 6'd0,  6'd41, 6'd0,  1'b1, 2'd1, 6'd40, 3'b111);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b1, 2'd1, 6'd41, 3'b111);
    tbl[18] = mk(1'b1, 1'b1, 1'b0, 3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 2'd0, 6'd0,  3'b111);

    for (int r = 0; r < 19; r++) begin
      rst_in    = tbl[r].rst;
      rdy_in    = tbl[r].rdy;
      roll_back = tbl[r].rb;
      set_src(0, tbl[r].vld[0], tbl[r].t0);
      set_src(1, tbl[r].vld[1], tbl[r].t1);
      set_src(2, tbl[r].vld[2], tbl[r].t2);
      @(negedge clk_in);
      chk($sformatf("row%0d_valid", r), 32'(cdb_valid), 32'(tbl[r].ev));
      chk($sformatf("row%0d_ready", r), 32'(src_ready), 32'(tbl[r].er));
      if (tbl[r].rdy) begin
        chk($sformatf("row%0d_src", r), 32'(cdb_src), tbl[r].ev ? 32'(tbl[r].es) : 32'd0);
        chk($sformatf("row%0d_entry", r), 32'(cdb_entry),
            tbl[r].ev ? 32'(tbl[r].ee) : 32'(CDB_ENTRY_NULL));
        chk($sformatf("row%0d_value", r), cdb_value,
            tbl[r].ev ? val_f(int'(tbl[r].es), tbl[r].ee) : 32'd0);
        chk($sformatf("row%0d_pc", r), cdb_pc,
            tbl[r].ev ? pc_f(int'(tbl[r].es), tbl[r].ee) : 32'd0);
      end
      tick();
    end

    mon_en = 1'b1;
    rdy_in = 1'b1; roll_back = 1'b0;
    reset_pulse();
    fair_round(6'd1);
    fair_round(6'd4);

    set_src(0, 1'b1, 6'd5);
    src_value[31:0] = 32'h0000_1234;
    src_pc[31:0]    = 32'h0000_0100;
    sb_push(0, 6'd5, 32'h0000_1234, 32'h0000_0100);
    tick();
    src_valid = 3'b000;
    @(negedge clk_in);
    chk("single_visible", 32'(cdb_valid), 32'd1);
    tick();
    @(negedge clk_in);
    chk("single_gone", 32'(cdb_valid), 32'd0);
    tick();

    reset_pulse();
    foreach (sb_q[k]) sb_q.delete(k);
    sb_push(0, 6'd20, val_f(0, 6'd20), pc_f(0, 6'd20));
    sb_push(1, 6'd8,  val_f(1, 6'd8),  pc_f(1, 6'd8));
    sb_push(0, 6'd21, val_f(0, 6'd21), pc_f(0, 6'd21));
    sb_push(1, 6'd9,  val_f(1, 6'd9),  pc_f(1, 6'd9));
    sb_push(0, 6'd22, val_f(0, 6'd22), pc_f(0, 6'd22));
    sb_push(1, 6'd10, val_f(1, 6'd10), pc_f(1, 6'd10));
    sb_push(0, 6'd23, val_f(0, 6'd23), pc_f(0, 6'd23));
    sb_push(0, 6'd24, val_f(0, 6'd24), pc_f(0, 6'd24));
    t0 = 20; t1 = 8;
    for (int c = 0; c < 20 && (t0 <= 24 || t1 <= 10); c++) begin
      set_src(0, t0 <= 24, 6'(t0));
      set_src(1, t1 <= 10, 6'(t1));
      @(negedge clk_in);
      if (c == 1) chk("bp_ready1_one_held", 32'(src_ready[1]), 32'd1);
      if (c == 2) chk("bp_ready1_two_held", 32'(src_ready[1]), 32'd0);
      acc0 = src_valid[0] & src_ready[0];
      acc1 = src_valid[1] & src_ready[1];
      tick();
      if (acc0) t0++;
      if (acc1) t1++;
    end
    chk("bp_all_accepted", 32'((t0 == 25) && (t1 == 11)), 32'd1);
    src_valid = 3'b000;
    repeat (6) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
